spm_scheduler: RTL and testbench

Round-robin scheduler that shares one serial-parallel multiplier (32x32 -> 64-bit) among N requesters. Each requester issues an operand pair through a valid/ready handshake. The scheduler sequences the multiplier's start/done protocol and captures the 64-bit product. It returns the product to the originating requester through a per-requester response handshake, with a watchdog that flags a stalled multiplier. It sits between the user-project request sources and the multiplier core.

---
 rtl/spm_scheduler.sv | 161 ++++++++++++++++
 tb/tb_spm_scheduler.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spm_scheduler.sv
// spm_scheduler: round-robin front end that shares one serial-parallel multiplier
// among N requesters. It runs the start/done protocol and has a watchdog on a stalled core.
`timescale 1ns/1ps
module spm_scheduler #(
    parameter int N       = 4,
    parameter int TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req_valid,
    output logic [N-1:0]      req_ready,
    input  logic [32*N-1:0]   req_mc,
    input  logic [32*N-1:0]   req_mp,
    output logic [N-1:0]      rsp_valid,
    input  logic [N-1:0]      rsp_ready,
    output logic [63:0]       rsp_prod,
    output logic              rsp_err,
    output logic [31:0]       spm_mc,
    output logic [31:0]       spm_mp,
    output logic              spm_start,
    input  logic [63:0]       spm_prod,
    input  logic              spm_done,
    output logic              busy
);
    localparam int IDW = (N > 1) ? $clog2(N) : 1;
    localparam int CW  = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] WDOG_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY, S_RESP} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [IDW-1:0]  r_last_grant;
    logic [IDW-1:0]  r_id;
    logic [CW-1:0]   r_wdog;
    logic [31:0]     r_spm_mc;
    logic [31:0]     r_spm_mp;
    logic            r_spm_start;
    logic            r_busy;
    logic [N-1:0]    r_rsp_valid;
    logic [63:0]     r_rsp_prod;
    logic            r_rsp_err;

    logic [IDW-1:0]  w_cand [N];
    logic [31:0]     w_mc_arr [N];
    logic [31:0]     w_mp_arr [N];
    logic            w_found;
    logic [IDW-1:0]  w_win;
    logic [N-1:0]    w_grant_oh;
    logic [N-1:0]    w_id_oh;
    logic            w_wdog_expired;

    // w_cand[k] is the requester examined k-th, starting just after the last grant.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_req
            assign w_cand[gi]   = IDW'((int'(r_last_grant) + gi + 1) % N);
            assign w_mc_arr[gi] = req_mc[32*gi +: 32];
            assign w_mp_arr[gi] = req_mp[32*gi +: 32];
        end
    endgenerate

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && req_valid[w_cand[k]]) begin
                w_found = 1'b1;
                w_win   = w_cand[k];
            end
        end
    end

    assign w_grant_oh     = w_found ? (N'(1) << w_win) : '0;
    assign w_id_oh        = N'(1) << r_id;
    assign w_wdog_expired = (r_wdog == WDOG_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_state_next = S_START;
            S_START: w_state_next = S_BUSY;
            S_BUSY:  if (spm_done || w_wdog_expired) w_state_next = S_RESP;
            S_RESP:  if (rsp_ready[r_id]) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // The grant is the only combinational output; it is forced low while reset is held.
    always_comb begin
        req_ready = '0;
        if ((r_state == S_IDLE) && rst) begin
            req_ready = w_grant_oh;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_grant <= IDW'(N - 1);
            r_id         <= '0;
            r_spm_mc     <= '0;
            r_spm_mp     <= '0;
            r_spm_start  <= 1'b0;
            r_busy       <= 1'b0;
            r_wdog       <= '0;
            r_rsp_valid  <= '0;
            r_rsp_prod   <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            r_spm_start <= (w_state_next == S_START);
            r_busy      <= (w_state_next != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_id         <= w_win;
                        r_last_grant <= w_win;
                        r_spm_mc     <= w_mc_arr[w_win];
                        r_spm_mp     <= w_mp_arr[w_win];
                    end
                end
                S_START: r_wdog <= '0;
                S_BUSY: begin
                    r_wdog <= r_wdog + CW'(1);
                    // A done arriving on the expiry cycle still delivers the real product.
                    if (spm_done) begin
                        r_rsp_prod  <= spm_prod;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= w_id_oh;
                    end else if (w_wdog_expired) begin
                        r_rsp_prod  <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= w_id_oh;
                    end
                end
                S_RESP: begin
                    if (rsp_ready[r_id]) begin
                        r_rsp_valid <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_prod  = r_rsp_prod;
    assign rsp_err   = r_rsp_err;
    assign spm_mc    = r_spm_mc;
    assign spm_mp    = r_spm_mp;
    assign spm_start = r_spm_start;
    assign busy      = r_busy;

endmodule

// File: tb/tb_spm_scheduler.sv
// Testbench for spm_scheduler: random and directed requests against a behavioural
// model of round-robin arbitration, multiplier latency and watchdog timing.
`timescale 1ns/1ps
module tb_spm_scheduler;
    localparam int N  = 4;
    localparam int TO = 72;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [32*N-1:0]   req_mc = '0;
    logic [32*N-1:0]   req_mp = '0;
    logic [N-1:0]      rsp_valid;
    logic [N-1:0]      rsp_ready = '1;
    logic [63:0]       rsp_prod;
    logic              rsp_err;
    logic [31:0]       spm_mc;
    logic [31:0]       spm_mp;
    logic              spm_start;
    logic [63:0]       spm_prod = '0;
    logic              spm_done = 1'b0;
    logic              busy;

    spm_scheduler #(.N(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_mc(req_mc), .req_mp(req_mp),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_prod(rsp_prod), .rsp_err(rsp_err),
        .spm_mc(spm_mc), .spm_mp(spm_mp), .spm_start(spm_start),
        .spm_prod(spm_prod), .spm_done(spm_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Reference model: one operation at a time, arbitration by rotating priority.
    typedef struct {
        int          id;
        logic [63:0] prod;
        bit          err;
        int          rise;
    } rsp_t;

    rsp_t        exp_q[$];
    rsp_t        cur;
    bit          m_out = 1'b0;
    bit          in_rsp = 1'b0;
    int          m_acc = 0;
    int          m_last = N - 1;
    int          m_lat = 0;
    logic [31:0] m_mc = '0;
    logic [31:0] m_mp = '0;
    int          lat_cfg [N];
    int          acc_cyc [N];
    int          hs_cyc [N];
    int          grant_log[$];
    logic [63:0] last_prod = '0;
    logic [N-1:0] last_valid = '0;
    logic        last_err = 1'b0;
    int          last_rise = 0;
    int          stray_cyc = -1;

    always @(negedge clk) begin
        logic [N-1:0] exp_rdy;
        int           win;
        int           c;
        rsp_t         e;
        logic [63:0]  a64;
        logic [63:0]  b64;
        if (!rst) begin
            m_out  = 1'b0;
            in_rsp = 1'b0;
            m_last = N - 1;
            exp_q.delete();
            chk("rst_req_ready", 64'(req_ready), 0);
            chk("rst_rsp_valid", 64'(rsp_valid), 0);
            chk("rst_busy", 64'(busy), 0);
            chk("rst_spm_start", 64'(spm_start), 0);
        end else begin
            exp_rdy = '0;
            win = -1;
            if (!m_out) begin
                for (int k = 1; k <= N; k++) begin
                    c = (m_last + k) % N;
                    if (win < 0 && req_valid[c]) win = c;
                end
            end
            if (win >= 0) exp_rdy = onehot(win);
            chk("req_ready", 64'(req_ready), 64'(exp_rdy));
            chk("busy", 64'(busy), 64'(m_out && cyc > m_acc));
            chk("spm_start", 64'(spm_start), 64'(m_out && cyc == m_acc + 1));
            if (m_out && cyc > m_acc && !in_rsp) begin
                chk("spm_mc", 64'(spm_mc), 64'(m_mc));
                chk("spm_mp", 64'(spm_mp), 64'(m_mp));
            end
            if (rsp_valid != '0) begin
                if (!in_rsp) begin
                    chk("rsp_expected", 64'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        cur = exp_q.pop_front();
                        in_rsp = 1'b1;
                        chk("rsp_rise_cycle", 64'(cyc), 64'(cur.rise));
                        chk("rsp_valid", 64'(rsp_valid), 64'(onehot(cur.id)));
                        chk("rsp_prod", rsp_prod, cur.prod);
                        chk("rsp_err", 64'(rsp_err), 64'(cur.err));
                        last_prod  = rsp_prod;
                        last_valid = rsp_valid;
                        last_err   = rsp_err;
                        last_rise  = cyc;
                    end
                end else begin
                    chk("rsp_hold_valid", 64'(rsp_valid), 64'(onehot(cur.id)));
                    chk("rsp_hold_prod", rsp_prod, cur.prod);
                    chk("rsp_hold_err", 64'(rsp_err), 64'(cur.err));
                end
            end else if (in_rsp) begin
                chk("rsp_dropped", 64'(rsp_valid), 64'(onehot(cur.id)));
                in_rsp = 1'b0;
                m_out  = 1'b0;
            end
            if (in_rsp && rsp_ready[cur.id]) begin
                in_rsp = 1'b0;
                m_out  = 1'b0;
                hs_cyc[cur.id] = cyc;
            end
            if (win >= 0) begin
                m_out  = 1'b1;
                m_acc  = cyc;
                m_last = win;
                m_mc   = req_mc[32*win +: 32];
                m_mp   = req_mp[32*win +: 32];
                m_lat  = lat_cfg[win];
                a64    = {32'd0, m_mc};
                b64    = {32'd0, m_mp};
                e.id   = win;
                e.err  = (m_lat == 0) || (m_lat > TO);
                e.prod = e.err ? 64'd0 : a64 * b64;
                e.rise = cyc + 2 + (e.err ? TO : m_lat);
                exp_q.push_back(e);
                grant_log.push_back(win);
                acc_cyc[win] = cyc;
            end
        end
    end

    // Multiplier model: done pulses m_lat cycles after the start cycle (0 = never).
    bit          pend = 1'b0;
    int          due = 0;
    logic [63:0] op_a = '0;
    logic [63:0] op_b = '0;
    always @(negedge clk) begin
        spm_done = 1'b0;
        spm_prod = {$urandom, $urandom};
        if (!rst) begin
            pend = 1'b0;
        end else begin
            if (pend && cyc == due) begin
                spm_done = 1'b1;
                spm_prod = op_a * op_b;
                pend = 1'b0;
            end
            if (cyc == stray_cyc) spm_done = 1'b1;
            if (spm_start) begin
                pend = (m_lat != 0);
                due  = cyc + m_lat;
                op_a = {32'd0, spm_mc};
                op_b = {32'd0, spm_mp};
            end
        end
    end

    task automatic send(input int i, input logic [31:0] a, input logic [31:0] b, input int lat);
        int n;
        lat_cfg[i] = lat;
        req_mc[32*i +: 32] = a;
        req_mp[32*i +: 32] = b;
        req_valid[i] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(rst && req_ready[i]) && n < 3000);
        chk("send_accepted", 64'(n < 3000), 1);
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_drain(input int max);
        int n;
        n = 0;
        while ((m_out || in_rsp || exp_q.size() != 0) && n < max) begin
            @(posedge clk);
            n++;
        end
        chk("drain", 64'(m_out || exp_q.size() != 0), 0);
        #1;
    endtask

    function automatic int rlat();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return 0;
        if (r == 1) return TO;
        return int'($urandom_range(1, 24));
    endfunction

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_order [5];
        int n;
        logic [N-1:0] mask;
        exp_order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < N; i++) begin
            lat_cfg[i] = 1;
            acc_cyc[i] = 0;
            hs_cyc[i]  = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        // Contention straight out of reset.
        grant_log.delete();
        fork
            begin
                send(0, 32'h0000_0011, 32'h0000_0003, 7);
                send(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 12);
            end
            send(1, 32'h1234_5678, 32'h0000_0010, 3);
            send(2, 32'h8000_0000, 32'h0000_0002, 15);
            send(3, 32'h0BAD_F00D, 32'h0000_1000, 1);
        join
        wait_drain(500);
        chk("contention_grants", 64'(grant_log.size()), 5);
        for (int k = 0; k < 5; k++) begin
            if (k < grant_log.size()) chk("contention_order", 64'(grant_log[k]), 64'(exp_order[k]));
        end

        // Single request with a 64-cycle multiplier.
        send(2, 32'h0000_FFFF, 32'h0001_0000, 64);
        wait_drain(300);
        chk("single_valid", 64'(last_valid), 64'(4'b0100));
        chk("single_prod", last_prod, 64'h0000_0000_FFFF_0000);
        chk("single_err", 64'(last_err), 0);

        // Stray done while idle.
        stray_cyc = cyc + 3;
        repeat (8) @(posedge clk);
        #1;
        stray_cyc = -1;
        chk("stray_no_rsp", 64'(rsp_valid), 0);
        chk("stray_idle", 64'(busy), 0);

        // Watchdog expiry, then a normal request.
        send(1, 32'hDEAD_BEEF, 32'h0000_0002, 0);
        wait_drain(300);
        chk("timeout_err", 64'(last_err), 1);
        chk("timeout_prod", last_prod, 0);
        chk("timeout_rise", 64'(last_rise - acc_cyc[1]), 64'(TO + 2));
        send(1, 32'd7, 32'd6, 5);
        wait_drain(300);
        chk("after_timeout_prod", last_prod, 64'd42);
        chk("after_timeout_err", 64'(last_err), 0);

        // Done on the same cycle the watchdog expires.
        send(2, 32'h0001_0001, 32'h0000_0100, TO);
        wait_drain(300);
        chk("tie_err", 64'(last_err), 0);
        chk("tie_prod", last_prod, 64'h0000_0000_0100_0100);

        // Back-pressure on requester 1 while requester 3 waits.
        rsp_ready = '1;
        rsp_ready[1] = 1'b0;
        send(1, 32'hCAFE_0001, 32'h0000_0005, 6);
        fork
            send(3, 32'h0000_1111, 32'h0000_2222, 8);
            begin
                n = 0;
                while (!rsp_valid[1] && n < 200) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                chk("bp_rsp_seen", 64'(rsp_valid[1]), 1);
                repeat (20) @(posedge clk);
                #1;
                rsp_ready[1] = 1'b1;
            end
        join
        wait_drain(500);
        chk("bp_accept_next_cycle", 64'(acc_cyc[3]), 64'(hs_cyc[1] + 1));

        // Random traffic from random subsets of requesters.
        for (int r = 0; r < 25; r++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            fork
                begin if (mask[0]) send(0, $urandom, $urandom, rlat()); end
                begin if (mask[1]) send(1, $urandom, $urandom, rlat()); end
                begin if (mask[2]) send(2, $urandom, $urandom, rlat()); end
                begin if (mask[3]) send(3, $urandom, $urandom, rlat()); end
            join
            wait_drain(2000);
        end

        // Reset while the multiplier is busy.
        send(2, 32'h1234_5678, 32'h9ABC_DEF0, 40);
        chk("rstb_started", 64'(spm_start), 1);
        repeat (10) @(posedge clk);
        #2;
        lat_cfg[0] = 4;
        req_mc[31:0] = 32'h0000_0101;
        req_mp[31:0] = 32'h0000_0003;
        req_valid[0] = 1'b1;
        grant_log.delete();
        rst = 1'b0;
        #1;
        chk("rstb_req_ready", 64'(req_ready), 0);
        chk("rstb_rsp_valid", 64'(rsp_valid), 0);
        chk("rstb_rsp_prod", rsp_prod, 0);
        chk("rstb_rsp_err", 64'(rsp_err), 0);
        chk("rstb_spm_start", 64'(spm_start), 0);
        chk("rstb_spm_mc", 64'(spm_mc), 0);
        chk("rstb_spm_mp", 64'(spm_mp), 0);
        chk("rstb_busy", 64'(busy), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        fork
            send(0, 32'h0000_0101, 32'h0000_0003, 4);
            send(3, 32'h0000_0010, 32'h0000_0010, 4);
        join
        wait_drain(500);
        chk("rstb_grants", 64'(grant_log.size()), 2);
        if (grant_log.size() > 0) chk("rstb_first_grant", 64'(grant_log[0]), 0);

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
